// File: rtl/dist_ram_burst_reader.sv
// Read-side burst engine for a 256x8 async-read distributed RAM.
// Walks a wrapping address range and streams each byte out over valid/ready with a last marker.
module dist_ram_burst_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_in,
  input  logic                  reset_n_in,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH-1:0] base_addr_in,
  input  logic [ADDR_WIDTH:0]   length_in,
  output logic [ADDR_WIDTH-1:0] ram_addr_out,
  input  logic [DATA_WIDTH-1:0] ram_data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  last_out,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam logic [ADDR_WIDTH:0]   MAX_LEN  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   ZERO_LEN = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   REM_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] ptr_r;
  logic [ADDR_WIDTH:0]   remaining_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  valid_r;
  logic                  last_r;
  logic                  busy_r;
  logic                  done_r;

  logic [ADDR_WIDTH:0]   len_clamped_s;
  logic                  capture_s;
  logic                  xfer_s;

  // Clamp the requested beat count to the RAM depth
  always_comb begin
    len_clamped_s = length_in;
    if (length_in > MAX_LEN) begin
      len_clamped_s = MAX_LEN;
    end else begin
      len_clamped_s = length_in;
    end
  end

  // The output register may load whenever it is empty or being drained this edge
  assign capture_s = !valid_r || ready_in;
  assign xfer_s    = valid_r && ready_in;

  // Burst FSM with all stream outputs registered
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_r     <= ST_IDLE;
      ptr_r       <= {ADDR_WIDTH{1'b0}};
      remaining_r <= ZERO_LEN;
      data_r      <= {DATA_WIDTH{1'b0}};
      valid_r     <= 1'b0;
      last_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_in) begin
            if (length_in == ZERO_LEN) begin
              done_r <= 1'b1;
            end else begin
              ptr_r       <= base_addr_in;
              remaining_r <= len_clamped_s;
              busy_r      <= 1'b1;
              state_r     <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (capture_s) begin
            data_r      <= ram_data_in;
            valid_r     <= 1'b1;
            last_r      <= (remaining_r == REM_ONE);
            ptr_r       <= ptr_r + PTR_ONE;
            remaining_r <= remaining_r - REM_ONE;
            if (remaining_r == REM_ONE) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Final beat is held until accepted, then the burst retires
          if (xfer_s) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          valid_r <= 1'b0;
          last_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign ram_addr_out = ptr_r;
  assign data_out     = data_r;
  assign valid_out    = valid_r;
  assign last_out     = last_r;
  assign busy_out     = busy_r;
  assign done_out     = done_r;

  dist_ram_burst_reader_chk #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_chk (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .valid      (valid_r),
    .ready      (ready_in),
    .last       (last_r),
    .done       (done_r),
    .data       (data_r)
  );

endmodule

// Stream protocol properties for the burst reader output.
module dist_ram_burst_reader_chk #(
  parameter int DATA_WIDTH = 8
) (
  input logic                  clk_in,
  input logic                  reset_n_in,
  input logic                  valid,
  input logic                  ready,
  input logic                  last,
  input logic                  done,
  input logic [DATA_WIDTH-1:0] data
);

  a_stall_hold: assert property (@(posedge clk_in) disable iff (!reset_n_in)
    (valid && !ready) |=> (valid && $stable(data) && $stable(last)));

  a_last_valid: assert property (@(posedge clk_in) disable iff (!reset_n_in)
    last |-> valid);

  a_done_pulse: assert property (@(posedge clk_in) disable iff (!reset_n_in)
    done |=> !done);

endmodule
